// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and vertical region encoding.
// Imported by the horizontal counter, the vertical sync block and decoders.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // First and last asserted positions of each sync pulse
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } v_state_t;

endpackage

// File: rtl/vga_h_decode.sv
// Combinational horizontal region decode: visible area and sync window.
// Positions at or beyond the line total decode as blank with sync idle.
module vga_h_decode
   import vga_timing_pkg::*;
#(
   parameter logic [9:0] ACT_END    = 10'(H_ACTIVE),
   parameter logic [9:0] SYNC_FIRST = 10'(H_SYNC_START),
   parameter logic [9:0] SYNC_LAST  = 10'(H_SYNC_END),
   parameter logic [9:0] TOTAL      = 10'(H_TOTAL)
) (
   input  logic [9:0] h_count,
   output logic       visible,
   output logic       sync_on
);

   logic in_range;

   assign in_range = h_count < TOTAL;
   assign visible  = in_range && (h_count < ACT_END);
   assign sync_on  = in_range && (h_count >= SYNC_FIRST)
                              && (h_count <= SYNC_LAST);

endmodule

// File: rtl/vga_v_sync.sv
// Vertical line counter and region FSM; registers sync, blanking,
// pixel coordinates and the frame-start pulse for the pixel pipeline.
module vga_v_sync
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP            = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP            = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP            = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP            = vga_timing_pkg::V_BP,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] h_count,
   input  logic       trig_v,
   output logic [9:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   // Last line of each vertical region
   localparam logic [9:0] VA_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0] VF_LAST = 10'(V_ACTIVE + V_FP - 1);
   localparam logic [9:0] VS_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] VT_LAST =
      10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   v_state_t   state;
   v_state_t   state_next;
   logic [9:0] v_next;
   logic       h_vis;
   logic       h_sync_on;
   logic       vis;

   vga_h_decode #(
      .ACT_END    (10'(H_ACTIVE)),
      .SYNC_FIRST (10'(H_ACTIVE + H_FP)),
      .SYNC_LAST  (10'(H_ACTIVE + H_FP + H_SYNC - 1)),
      .TOTAL      (10'(H_ACTIVE + H_FP + H_SYNC + H_BP))
   ) u_h_decode (
      .h_count (h_count),
      .visible (h_vis),
      .sync_on (h_sync_on)
   );

   assign vis = h_vis && (state == ST_ACTIVE);

   always_comb begin
      v_next     = v_count;
      state_next = state;
      if (trig_v) begin
         v_next = (v_count == VT_LAST) ? '0 : v_count + 10'd1;
         case (state)
            ST_ACTIVE: if (v_count == VA_LAST) state_next = ST_FRONT;
            ST_FRONT:  if (v_count == VF_LAST) state_next = ST_SYNC;
            ST_SYNC:   if (v_count == VS_LAST) state_next = ST_BACK;
            ST_BACK:   if (v_count == VT_LAST) state_next = ST_ACTIVE;
            default:   state_next = ST_ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_ACTIVE;
         v_count     <= '0;
         hsync       <= SYNC_ACTIVE_LOW;
         vsync       <= SYNC_ACTIVE_LOW;
         video_on    <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_next;
         v_count     <= v_next;
         hsync       <= h_sync_on ^ SYNC_ACTIVE_LOW;
         vsync       <= (state == ST_SYNC) ^ SYNC_ACTIVE_LOW;
         video_on    <= vis;
         pixel_x     <= vis ? h_count : '0;
         pixel_y     <= vis ? v_count : '0;
         // Marks the first clock of line 0 after a natural wrap only
         frame_start <= trig_v && (v_count == VT_LAST);
      end
   end

endmodule

// File: tb/tb_vga_v_sync.sv
// Directed plus random stimulus for vga_v_sync against a line-number model.
module tb_vga_v_sync;

   logic       clk;
   logic       reset;
   logic [9:0] h_count;
   logic       trig_v;
   logic [9:0] v_count;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_start;

   int total = 0;
   int bad   = 0;

   int mv = 0;
   int e_vc, e_hs, e_vs, e_vid, e_px, e_py, e_fs;
   int hs_low, vs_low, vid_hi, fs_cnt;

   vga_v_sync dut (
      .clk         (clk),
      .reset       (reset),
      .h_count     (h_count),
      .trig_v      (trig_v),
      .v_count     (v_count),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, step the line-number model, check outputs
   task automatic cyc(input int h, input bit t);
      int  pv;
      bit  vis;
      h_count = 10'(h);
      trig_v  = t;
      @(posedge clk);
      #1;
      if (reset) begin
         mv = 0;
         e_vc = 0; e_hs = 1; e_vs = 1; e_vid = 0;
         e_px = 0; e_py = 0; e_fs = 0;
      end else begin
         pv    = mv;
         vis   = (h < 640) && (pv < 480);
         e_hs  = (h >= 656 && h <= 751) ? 0 : 1;
         e_vs  = (pv >= 490 && pv <= 491) ? 0 : 1;
         e_vid = vis ? 1 : 0;
         e_px  = vis ? h : 0;
         e_py  = vis ? pv : 0;
         e_fs  = (t && pv == 524) ? 1 : 0;
         if (t) mv = (pv + 1) % 525;
         e_vc  = mv;
      end
      chk("v_count", v_count, e_vc);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("video_on", video_on, e_vid);
      chk("pixel_x", pixel_x, e_px);
      chk("pixel_y", pixel_y, e_py);
      chk("frame_start", frame_start, e_fs);
      if (hsync == 1'b0) hs_low++;
      if (vsync == 1'b0) vs_low++;
      if (video_on == 1'b1) vid_hi++;
      if (frame_start == 1'b1) fs_cnt++;
   endtask

   // Compressed line: two random mid-line clocks, then the end-of-line pulse
   task automatic line_fast();
      cyc(int'($urandom_range(0, 799)), 1'b0);
      cyc(int'($urandom_range(0, 799)), 1'b0);
      cyc(799, 1'b1);
   endtask

   initial begin
      reset   = 1'b1;
      h_count = '0;
      trig_v  = 1'b0;
      hs_low = 0; vs_low = 0; vid_hi = 0; fs_cnt = 0;

      cyc(0, 1'b0);
      cyc(0, 1'b0);
      reset = 1'b0;
      cyc(0, 1'b0);

      // Full line 0
      hs_low = 0; vid_hi = 0;
      for (int h = 0; h < 800; h++) cyc(h, h == 799);
      chk("line0_video_cnt", vid_hi, 640);
      chk("line0_hsync_cnt", hs_low, 96);
      chk("v_after_line0", v_count, 1);

      // Last visible pixel of the frame
      while (mv != 479) line_fast();
      cyc(639, 1'b0);
      chk("last_px_x", pixel_x, 639);
      chk("last_px_y", pixel_y, 479);
      chk("last_px_vid", video_on, 1);
      cyc(799, 1'b1);

      // Line 480 entirely blank
      vid_hi = 0;
      for (int h = 0; h < 800; h++) cyc(h, h == 799);
      chk("line480_video_cnt", vid_hi, 0);

      // Rest of the frame through the wrap
      vs_low = 0; fs_cnt = 0;
      while (mv != 0) line_fast();
      cyc(10, 1'b0);
      chk("frame_fs_cnt", fs_cnt, 1);
      chk("frame_vsync_cnt", vs_low, 6);

      // Asynchronous reset while in the vertical sync region
      while (mv != 491) line_fast();
      cyc(100, 1'b0);
      chk("in_sync_vsync", vsync, 0);
      #2 reset = 1'b1;
      #1;
      chk("async_vsync", vsync, 1);
      chk("async_v_count", v_count, 0);
      mv = 0;
      cyc(0, 1'b0);
      reset = 1'b0;
      fs_cnt = 0;
      cyc(5, 1'b0);
      cyc(799, 1'b1);
      chk("v_after_reset", v_count, 1);
      chk("no_fs_after_reset", fs_cnt, 0);

      // Misaligned trig_v and out-of-range h_count
      cyc(300, 1'b1);
      chk("v_mid_trig", v_count, 2);
      cyc(900, 1'b0);
      chk("oor_video", video_on, 0);
      chk("oor_hsync", hsync, 1);

      // Random stretch, long enough to cross at least one frame wrap
      for (int i = 0; i < 3000; i++)
         cyc(int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_v_sync.md
Name: vga_v_sync

Overview:
- Downstream neighbour of the horizontal pixel counter in the VGA display path.
- Consumes the horizontal count `h_count` and the end-of-line pulse `trig_v`.
- Maintains the vertical line counter and runs a vertical-region state machine.
- Produces registered `hsync`, `vsync`, `video_on`, `pixel_x`, `pixel_y` and `frame_start` for the pixel generator and the VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks); H_TOTAL = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while asserted

Ports:
- clk  input  1  pixel clock, rising edge
- reset  input  1  asynchronous, active-high reset
- h_count  input  10  horizontal position from the horizontal counter, 0..H_TOTAL-1
- trig_v  input  1  one-clock pulse, high during the cycle h_count == H_TOTAL-1
- v_count  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  output  1  high when the pixel is in the visible area
- pixel_x  output  10  h_count when visible, else 0
- pixel_y  output  10  v_count when visible, else 0
- frame_start  output  1  one-clock pulse at start of line 0

Behaviour:
- Reset (async, active-high) sets:
  - v_count = 0
  - state = V_ACTIVE
  - hsync = vsync = inactive level (1 with default polarity)
  - video_on = 0, pixel_x = pixel_y = 0, frame_start = 0
- Reset mid-frame: same values; counting resumes on the first trig_v after reset deasserts.
- v_count update:
  - Increments on each rising edge where trig_v = 1, so it changes on the same edge that h_count wraps 799 -> 0.
  - At V_TOTAL-1 (524) it wraps to 0.
  - trig_v is trusted; v_count still advances if trig_v arrives while h_count != 799.
- Vertical FSM, advanced only on trig_v edges:
  - V_ACTIVE: lines 0..479; leaves for V_FRONT when v_count 479 -> 480.
  - V_FRONT: lines 480..489; leaves for V_SYNC at 489 -> 490.
  - V_SYNC: lines 490..491; leaves for V_BACK at 491 -> 492.
  - V_BACK: lines 492..524; leaves for V_ACTIVE at 524 -> 0.
  - Invariant: state always matches the region of v_count.
- Output registers (1-clock latency): hsync, vsync, video_on, pixel_x, pixel_y are computed from h_count and v_count as they stand before the edge.
  - hsync asserted iff 656 <= h_count <= 751.
  - vsync asserted iff state == V_SYNC.
  - video_on = (h_count < 640) && (state == V_ACTIVE).
  - pixel_x/pixel_y track the counts when video_on is 1, otherwise 0.
- frame_start is high for exactly the one clock in which v_count first reads 0 after wrapping from 524. It is not pulsed by reset.
- h_count out of range (>= 800): video_on = 0, hsync inactive, no counter effect.
- Width rules: all comparisons are unsigned 10-bit. Parameter totals must fit in 10 bits (<= 1023); the default timing satisfies this.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the H_* and V_* default constants and the derived H_TOTAL, V_TOTAL
  - the sync start/end positions
  - the 2-bit vertical state encoding: V_ACTIVE = 0, V_FRONT = 1, V_SYNC = 2, V_BACK = 3
- The horizontal counter imports the same H_TOTAL.
- No sub-module required. The horizontal region compare may optionally be factored into vga_h_decode, a combinational helper.

Test Plan:
- Reset held, then released at h_count = 0 -> v_count = 0, video_on = 0, hsync = vsync = 1 and frame_start = 0 until the first stimulus.
- Drive h_count 0..799 with trig_v at 799 on line 0 ->
  - video_on = 1 for h_count 0..639, one clock late
  - hsync = 0 for exactly 96 clocks, covering h_count 656..751
  - v_count = 1 after the trig_v edge
- Run a full frame of 525 trig_v pulses ->
  - vsync = 0 only while v_count is 490..491, i.e. 1600 clocks
  - state sequence ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE
  - frame_start pulses once, as v_count goes 524 -> 0
- At v_count = 479, h_count = 639 then trig_v -> pixel_x = 639 and pixel_y = 479 the next clock; video_on = 0 for all of line 480.
- Assert reset at v_count = 491 in V_SYNC -> vsync goes inactive immediately (async) and v_count = 0; the next trig_v gives v_count = 1 with no frame_start.
- trig_v with h_count = 300, plus h_count = 900 injected -> v_count still increments; for h_count = 900, video_on = 0 and hsync is inactive.
